// File: rtl/mem_dump_tx_pkg.sv
// Shared definitions for the memory readback transmitter and its UART byte serializer.
// The CKSUM state exists only when DUMP_CHECKSUM_EN is defined.
package mem_dump_tx_pkg;

    // Clocks per UART bit; kept equal to the loader's and SingleUartTx's rate.
    localparam int unsigned SerialWcntDefault = 20;

    // Idle-high cycles between consecutive words (READ and LATCH).
    localparam int unsigned WordGapCycles = 2;

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StSend,
        StCksum,
        StFin
    } dump_state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StSend,
        StFin
    } dump_state_e;
`endif

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_dump_tx_uart_tx_byte.sv
// 8N1 byte serializer: bit-period counter plus a 10-bit frame shifter.
// READY is also high in the last cycle of a stop bit so frames can run back-to-back.
module uart_tx_byte
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned SERIAL_WCNT = SerialWcntDefault
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic       LOAD,
    input  logic [7:0] DATA,
    output logic       TXD,
    output logic       READY
);

    localparam int unsigned CntW = (SERIAL_WCNT > 2) ? $clog2(SERIAL_WCNT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SERIAL_WCNT - 1);

    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_q;
    logic [9:0]      frame_q;
    logic            busy_q;
    logic            bit_end;
    logic            frame_end;

    assign bit_end   = busy_q && (cnt_q == CntLast);
    assign frame_end = bit_end && (bit_q == 4'd9);
    assign READY     = !busy_q || frame_end;
    assign TXD       = busy_q ? frame_q[0] : 1'b1;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            busy_q  <= 1'b0;
        end else if (LOAD && READY) begin
            // Stop bit, data LSB-first, start bit in frame_q[0].
            frame_q <= {1'b1, DATA, 1'b0};
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else if (busy_q) begin
            if (bit_end) begin
                cnt_q <= '0;
                if (bit_q == 4'd9) begin
                    busy_q <= 1'b0;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    frame_q <= {1'b1, frame_q[9:1]};
                end
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// Reads NWORDS dmem words from BASE_ADDR and streams them out on TXD, little-endian, 8N1.
// Defining DUMP_CHECKSUM_EN appends a mod-256 sum of all data bytes as a trailing byte.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned SERIAL_WCNT = SerialWcntDefault,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             START,
    input  logic [31:0]      BASE_ADDR,
    input  logic [CNT_W-1:0] NWORDS,
    output logic [31:0]      MEM_ADDR,
    input  logic [31:0]      MEM_RDATA,
    output logic             TXD,
    output logic             BUSY,
    output logic             DONE
);

    dump_state_e      state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      word_q, word_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic             cks_loaded_q, cks_loaded_d;
`endif

    logic       tx_load;
    logic [7:0] tx_data;
    logic       tx_ready;

    uart_tx_byte #(
        .SERIAL_WCNT(SERIAL_WCNT)
    ) u_tx (
        .CLK  (CLK),
        .RST_X(RST_X),
        .LOAD (tx_load),
        .DATA (tx_data),
        .TXD  (TXD),
        .READY(tx_ready)
    );

    assign MEM_ADDR = mem_addr_q;
    assign BUSY     = (state_q != StIdle) && (state_q != StFin);
    assign DONE     = (state_q == StFin);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
`ifdef DUMP_CHECKSUM_EN
        sum_d        = sum_q;
        cks_loaded_d = cks_loaded_q;
`endif
        tx_load    = 1'b0;
        tx_data    = word_q[7:0];

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    addr_d     = word_align(BASE_ADDR);
                    mem_addr_d = word_align(BASE_ADDR);
                    cnt_d      = NWORDS;
`ifdef DUMP_CHECKSUM_EN
                    sum_d        = 8'h00;
                    cks_loaded_d = 1'b0;
                    state_d      = (NWORDS == '0) ? StCksum : StRead;
`else
                    state_d      = (NWORDS == '0) ? StFin : StRead;
`endif
                end
            end
            StRead: begin
                state_d = StLatch;
            end
            StLatch: begin
                // Read data is valid now; byte 0 starts at the same edge it is captured.
                tx_load    = 1'b1;
                tx_data    = MEM_RDATA[7:0];
                word_d     = MEM_RDATA[31:8];
                byte_idx_d = 2'd0;
`ifdef DUMP_CHECKSUM_EN
                sum_d      = sum_q + MEM_RDATA[7:0];
`endif
                state_d    = StSend;
            end
            StSend: begin
                if (tx_ready) begin
                    if (byte_idx_q != 2'd3) begin
                        tx_load    = 1'b1;
                        tx_data    = word_q[7:0];
                        word_d     = {8'h00, word_q[23:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
`ifdef DUMP_CHECKSUM_EN
                        sum_d      = sum_q + word_q[7:0];
`endif
                    end else begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        addr_d = addr_q + 32'd4;
                        if (cnt_q != CNT_W'(1)) begin
                            mem_addr_d = addr_q + 32'd4;
                            state_d    = StRead;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            tx_load      = 1'b1;
                            tx_data      = sum_q;
                            cks_loaded_d = 1'b1;
                            state_d      = StCksum;
`else
                            state_d      = StFin;
`endif
                        end
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            StCksum: begin
                // Entered either with the checksum already loaded, or idle for NWORDS==0.
                if (tx_ready) begin
                    if (cks_loaded_q) begin
                        state_d = StFin;
                    end else begin
                        tx_load      = 1'b1;
                        tx_data      = sum_q;
                        cks_loaded_d = 1'b1;
                    end
                end
            end
`endif
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q        <= '0;
            cks_loaded_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q        <= sum_d;
            cks_loaded_q <= cks_loaded_d;
`endif
        end
    end

endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Memory readback transmitter: the reverse of the UART program loader. On a start pulse it reads a contiguous range of data-memory words and serializes them over a UART TXD line (8N1, little-endian byte order), so a host can retrieve the results a program left in dmem. It sits beside the loader in the FPGA top level. It shares the dmem read port with the core while the core is held in reset or finished, and shares TXD through a top-level mux.

## Interface
Parameters:
- SERIAL_WCNT, 20: clocks per UART bit (≥ 2).
- CNT_W, 16: width of the word-count input.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST_X  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE_ADDR  in  32  byte address of first word; bits [1:0] ignored (treated as 0).
- NWORDS  in  CNT_W  number of 32-bit words to send.
- MEM_ADDR  out  32  byte address presented to dmem.
- MEM_RDATA  in  32  dmem read data, valid the cycle after MEM_ADDR is presented (synchronous RAM).
- TXD  out  1  serial output, idle high.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse when the transfer completes.

## Operation
- States: IDLE, READ, LATCH, SEND, CKSUM (only when configured), FIN.
- IDLE, START=1:
  - Latch BASE_ADDR&~3 into the address register and NWORDS into the remaining-count register.
  - If NWORDS==0, go to FIN. Otherwise go to READ.
- READ: MEM_ADDR = address register. Go to LATCH.
- LATCH: go to SEND.
- SEND entry: capture MEM_RDATA into the word shift register.
- SEND:
  - Transmit bytes [7:0], [15:8], [23:16], [31:24] in that order.
  - Each byte is sent as start bit (0), 8 data bits LSB first, stop bit (1).
  - After byte 3's stop bit, decrement the remaining count and add 4 to the address (wraps modulo 2^32).
  - If the count is now nonzero, go to READ. If zero, go to CKSUM (if configured) or FIN.
- FIN: DONE=1 for one cycle, then IDLE.
- START outside IDLE is ignored, not queued.
- BASE_ADDR and NWORDS are don't-care after the accept cycle.
- MEM_ADDR holds its last value outside READ. The top level may ignore it when BUSY=0.
- RST_X low at any time, including mid-byte: all state clears immediately (asynchronously). A partial byte is abandoned and TXD returns high.

## Timing
- Reset values: TXD=1, BUSY=0, DONE=0, MEM_ADDR=0, state=IDLE.
- START accepted at edge E0: BUSY=1 and MEM_ADDR=base after E0.
- Word data is captured at E2. The start bit drives TXD from E2 onward.
- Each bit lasts exactly SERIAL_WCNT cycles, so each byte lasts 10·SERIAL_WCNT cycles.
- Bytes within a word are back-to-back, with no extra idle time.
- Between words there are exactly 2 idle-high cycles (READ, LATCH).
- Per word: 2 + 40·SERIAL_WCNT cycles.
- DONE is asserted in the cycle after the final stop bit ends. BUSY falls together with DONE.
- A new START is accepted in the cycle after DONE.
- NWORDS==0: DONE is high in the cycle after E0 and TXD stays high throughout.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - After the last word, send one extra byte: the sum modulo 256 of all transmitted data bytes. Framing and timing are the same as a data byte.
  - The checksum is reset at START.
  - With NWORDS==0, the byte 0x00 is sent.
- Not defined: there is no CKSUM state and no checksum logic. DONE follows the last data byte directly.

## Structure
- Shared package holds:
  - state encodings;
  - the default SERIAL_WCNT constant, shared with the loader and SingleUartTx so baud rates match;
  - the per-word idle gap constant (2).
- One sub-module, uart_tx_byte:
  - Inputs: CLK, RST_X, LOAD, DATA[7:0].
  - Outputs: TXD, READY.
  - Contains the bit-period counter and 10-bit frame shifter.
  - READY high when idle. LOAD is only accepted when READY.
- mem_dump_tx owns the word/byte sequencing, address and count registers, and the checksum.

## Test plan
All scenarios use SERIAL_WCNT=4 and model dmem as a 1-cycle synchronous RAM.
- Single word, BASE_ADDR=0x100, NWORDS=1, mem[0x100]=0x12345678:
  - TXD decodes bytes 78 56 34 12.
  - DONE pulses exactly 2+160 cycles after the accept edge.
- Three words from 0x200 containing 0xDEADBEEF, 0x00000000, 0xFFFFFFFF:
  - TXD decodes 12 bytes in order.
  - Exactly 2 idle cycles before each word's first start bit.
  - MEM_ADDR sequence is 0x200, 0x204, 0x208.
- NWORDS=0:
  - DONE in the cycle after accept; TXD never low (without the macro).
  - With DUMP_CHECKSUM_EN, a single 0x00 byte is sent.
- Checksum with DUMP_CHECKSUM_EN, words 0x01020304 and 0x000000FF: trailing byte is 0x09.
- START pulsed again mid-transfer: ignored; byte stream and DONE timing are unchanged.
- Reset mid-byte:
  - TXD=1, BUSY=0 immediately on RST_X low.
  - After release, a fresh START with BASE_ADDR=0x3FC, NWORDS=2 reads 0x3FC then 0x400 correctly.
